// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Round-robin arbiter sharing the single register-file write port between
// NREQ write-back requesters. Grants are combinational (REQ_READY), the write
// itself is registered and presented on WR_* one cycle after acceptance.
module regfile_write_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 8,
   parameter int AW   = 3,
   parameter int CW   = 16
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 HOLD,
   input  logic [NREQ-1:0]      REQ_VALID,
   input  logic [NREQ*AW-1:0]   REQ_ADDR,
   input  logic [NREQ*DW-1:0]   REQ_DATA,
   output logic [NREQ-1:0]      REQ_READY,
   output logic                 WR_EN,
   output logic [AW-1:0]        WR_ADDR,
   output logic [DW-1:0]        WR_DATA,
   output logic [2:0]           WR_SRC,
   output logic [CW-1:0]        WR_CNT
);

   // Pointer wide enough to name every requester (at least one bit).
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PW:0]   NREQ_W = (PW+1)'(NREQ);
   localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

   logic [PW-1:0]   ptr_q;
   logic [PW-1:0]   ptr_d;
   logic [PW-1:0]   gidx_d;
   logic [NREQ-1:0] grant_d;
   logic            found_d;
   logic [PW:0]     scan_d;
   logic            xfer_d;

   logic            wr_en_q;
   logic [AW-1:0]   wr_addr_q;
   logic [DW-1:0]   wr_data_q;
   logic [2:0]      wr_src_q;
   logic [CW-1:0]   wr_cnt_q;

   // Unpacked views of the per-requester address and data buses.
   logic [AW-1:0] addr_arr [NREQ];
   logic [DW-1:0] data_arr [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign addr_arr[gi] = REQ_ADDR[gi*AW +: AW];
         assign data_arr[gi] = REQ_DATA[gi*DW +: DW];
      end
   endgenerate

   // Scan from the pointer, wrapping, and pick the first valid requester.
   always_comb begin
      grant_d = '0;
      gidx_d  = '0;
      found_d = 1'b0;
      scan_d  = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_d = {1'b0, ptr_q} + (PW+1)'(k);
         if (scan_d >= NREQ_W) begin
            scan_d = scan_d - NREQ_W;
         end
         if (!found_d && REQ_VALID[scan_d[PW-1:0]]) begin
            found_d                  = 1'b1;
            gidx_d                   = scan_d[PW-1:0];
            grant_d[scan_d[PW-1:0]]  = 1'b1;
         end
      end
   end

   // Grants are suppressed while stalled or in reset; a transfer is any grant.
   always_comb begin
      REQ_READY = (RESET || HOLD) ? '0 : grant_d;
      xfer_d    = |REQ_READY;
      ptr_d     = ptr_q;
      if (xfer_d) begin
         ptr_d = (gidx_d == LAST_IDX) ? '0 : gidx_d + PW'(1);
      end
   end

   // Register the accepted write, advance the pointer and count transfers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ptr_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_src_q  <= '0;
         wr_cnt_q  <= '0;
      end else begin
         ptr_q   <= ptr_d;
         wr_en_q <= xfer_d;
         if (xfer_d) begin
            wr_addr_q <= addr_arr[gidx_d];
            wr_data_q <= data_arr[gidx_d];
            wr_src_q  <= 3'(gidx_d);
            if (wr_cnt_q != '1) begin
               wr_cnt_q <= wr_cnt_q + CW'(1);
            end
         end
      end
   end

   assign WR_EN   = wr_en_q;
   assign WR_ADDR = wr_addr_q;
   assign WR_DATA = wr_data_q;
   assign WR_SRC  = wr_src_q;
   assign WR_CNT  = wr_cnt_q;

endmodule
